// File: rtl/h80cpu_biu.sv
// h80 bus interface unit: runs one core load/store at a time as one or two bus cycles.
// Define H80_BIU_UNALIGNED_EN to split unaligned word accesses into two byte cycles.
module h80cpu_biu #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int WAIT_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req,
  input  logic                      we,
  input  logic                      byte_en,
  input  logic [BUS_ADDR_WIDTH-1:0] addr_in,
  input  logic [BUS_DATA_WIDTH-1:0] wdata,
  output logic [BUS_DATA_WIDTH-1:0] rdata,
  output logic                      ack,
  output logic                      err,
  output logic                      ce_n,
  output logic [BUS_ADDR_WIDTH-1:0] addr,
  output logic [BUS_CMD_WIDTH-1:0]  cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] data_,
  input  logic                      wait_n
);
  localparam int AW    = BUS_ADDR_WIDTH;
  localparam int DW    = BUS_DATA_WIDTH;
  localparam int CW    = BUS_CMD_WIDTH;
  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  // bit 0 set means read
  localparam logic [CW-1:0] CMD_WRITE_W = CW'(2);
  localparam logic [CW-1:0] CMD_READ_W  = CW'(3);
  localparam logic [CW-1:0] CMD_WRITE_B = CW'(4);
  localparam logic [CW-1:0] CMD_READ_B  = CW'(5);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_ACK} state_t;

  state_t              r_state, w_next;
  logic                r_we, r_bw, r_split, r_part;
  logic [AW-1:0]       r_addr;
  logic [CW-1:0]       r_cmd;
  logic [DW-1:0]       r_wdrv, r_rbuf, r_rdata;
  logic [7:0]          r_whi;
  logic                r_err;
  logic [CNT_W-1:0]    r_wcnt;

  logic                w_accept, w_reject, w_adv, w_fin, w_abort, w_capture;
  logic                w_unal, w_bw, w_to, w_last, w_bus;
  logic [DW-1:0]       w_rbuf_nxt;

  function automatic logic [CW-1:0] f_cmd(input logic is_wr, input logic is_byte);
    case ({is_byte, is_wr})
      2'b00:   f_cmd = CMD_READ_W;
      2'b01:   f_cmd = CMD_WRITE_W;
      2'b10:   f_cmd = CMD_READ_B;
      default: f_cmd = CMD_WRITE_B;
    endcase
  endfunction

  assign w_unal = !byte_en && addr_in[0];
  assign w_bw   = byte_en || w_unal;
  assign w_bus  = (r_state == S_T1) || (r_state == S_T2);
  assign w_last = !r_split || r_part;
  assign w_to   = (WAIT_TIMEOUT != 0) && !wait_n && (r_wcnt == TO_LAST);

  // Second half of a split read lands in the upper lane; byte reads zero-extend.
  always_comb begin
    w_rbuf_nxt = r_rbuf;
    if (r_split && r_part) w_rbuf_nxt[15:8] = data_[7:0];
    else if (r_bw)         w_rbuf_nxt = {{(DW-8){1'b0}}, data_[7:0]};
    else                   w_rbuf_nxt = data_;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_adv     = 1'b0;
    w_fin     = 1'b0;
    w_abort   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: if (req) begin
        w_accept = 1'b1;
`ifdef H80_BIU_UNALIGNED_EN
        w_next = S_T1;
`else
        if (w_unal) begin
          w_reject = 1'b1;
          w_next   = S_ACK;
        end else begin
          w_next = S_T1;
        end
`endif
      end
      S_T1: begin
        if (!wait_n) begin
          if (w_to) begin w_abort = 1'b1; w_next = S_ACK; end
        end else if (!r_we) begin
          w_next = S_T2;
        end else if (w_last) begin
          w_fin = 1'b1; w_next = S_ACK;
        end else begin
          w_adv = 1'b1; w_next = S_T1;
        end
      end
      S_T2: begin
        if (!wait_n) begin
          if (w_to) begin w_abort = 1'b1; w_next = S_ACK; end
        end else begin
          w_capture = 1'b1;
          if (w_last) begin w_fin = 1'b1; w_next = S_ACK; end
          else        begin w_adv = 1'b1; w_next = S_T1;  end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_bw    <= 1'b0;
      r_split <= 1'b0;
      r_part  <= 1'b0;
      r_addr  <= '0;
      r_cmd   <= '0;
      r_wdrv  <= '0;
      r_whi   <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= we;
        r_bw    <= w_bw;
        r_split <= w_unal;
        r_part  <= 1'b0;
        r_addr  <= addr_in;
        r_cmd   <= f_cmd(we, w_bw);
        r_wdrv  <= w_bw ? {{(DW-8){1'b0}}, wdata[7:0]} : wdata;
        r_whi   <= wdata[15:8];
        r_wcnt  <= '0;
      end else if (w_adv) begin
        r_part  <= 1'b1;
        r_addr  <= r_addr + AW'(1);
        r_wdrv  <= {{(DW-8){1'b0}}, r_whi};
        r_wcnt  <= '0;
      end else if (w_bus) begin
        r_wcnt  <= (wait_n || w_abort) ? '0 : r_wcnt + CNT_W'(1);
      end
      if (w_capture) r_rbuf <= w_rbuf_nxt;
      if (w_fin) begin
        r_err   <= 1'b0;
        r_rdata <= r_we ? '0 : w_rbuf_nxt;
      end else if (w_abort || w_reject) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign ce_n  = !w_bus;
  assign addr  = r_addr;
  assign cmd   = r_cmd;
  assign ack   = (r_state == S_ACK);
  assign err   = r_err;
  assign rdata = r_rdata;
  assign data_ = (w_bus && !r_cmd[0]) ? r_wdrv : {DW{1'bz}};

endmodule

// File: tb/tb_h80cpu_biu.sv
// Bench for h80cpu_biu: byte-addressed bus slave, reference memory and an ack-driven scoreboard.
module tb_h80cpu_biu;
  localparam int TO = 4;
  localparam logic [2:0] C_WRITE_W = 3'd2, C_READ_W = 3'd3, C_WRITE_B = 3'd4, C_READ_B = 3'd5;

  logic        clk = 1'b0, reset_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, byte_en = 1'b0, wait_n = 1'b1;
  logic [15:0] addr_in = '0, wdata = '0;
  logic [15:0] rdata, addr;
  logic        ack, err, ce_n;
  logic [2:0]  cmd;
  wire  [15:0] data_;

  int checks = 0, fails = 0, cyc = 0, last_fall = 0;
  int wmode = 0, wlow_n = 0;
  logic [2:0] seen_cmd;

  logic [7:0] smem [65536];
  logic [7:0] refm [65536];

  typedef struct {logic rd; logic err; logic [15:0] data;} exp_t;
  exp_t sbq[$];

  h80cpu_biu #(.BUS_ADDR_WIDTH(16), .BUS_CMD_WIDTH(3), .BUS_DATA_WIDTH(16), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_en(byte_en), .addr_in(addr_in),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .ce_n(ce_n), .addr(addr), .cmd(cmd),
    .data_(data_), .wait_n(wait_n));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bus slave: little-endian byte memory; byte reads put junk in the upper lane.
  logic [15:0] s_rd, s_a1;
  always_comb begin
    s_a1 = addr + 16'd1;
    if (cmd == C_READ_B) s_rd = {8'hC3, smem[addr]};
    else                 s_rd = {smem[s_a1], smem[addr]};
  end
  assign data_ = (!ce_n && cmd[0]) ? s_rd : 16'hzzzz;

  initial begin
    for (int i = 0; i < 65536; i++) smem[i] = 8'(i * 7 + 3);
    forever begin
      @(negedge clk);
      if (reset_n && !ce_n && !cmd[0] && wait_n) begin
        smem[addr] = data_[7:0];
        if (cmd == C_WRITE_W) smem[addr + 16'd1] = data_[15:8];
      end
    end
  end

  // wait_n: 0 = ready, 1 = random (at most 3 lows in a row), 2 = stuck low, 3 = first wlow_n bus cycles low
  initial begin
    int run = 0;
    int wl  = 0;
    forever begin
      @(posedge clk); #1;
      case (wmode)
        0: wait_n = 1'b1;
        1: begin
          if (run < 3 && $urandom_range(0, 2) == 0) begin wait_n = 1'b0; run++; end
          else begin wait_n = 1'b1; run = 0; end
        end
        2: wait_n = 1'b0;
        default: begin
          if (ce_n) begin wl = 0; wait_n = 1'b1; end
          else if (wl < wlow_n) begin wait_n = 1'b0; wl++; end
          else wait_n = 1'b1;
        end
      endcase
    end
  end

  // Monitor: every ack is checked against the oldest expectation.
  initial begin
    logic prev = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ack) begin
        chk("ack_ce_n_high", ce_n, 1);
        checks++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack actual=ack expected=none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("ack_err", err, e.err);
          if (e.rd || e.err) chk("ack_rdata", rdata, e.data);
        end
      end
      if (!ce_n && prev) last_fall = cyc;
      prev = ce_n;
    end
  end

  task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                       input logic exp_to, output int lat, output int ce_lows, output int ack_c);
    exp_t e;
    logic unal;
    logic [15:0] a1;
    logic done;
    unal = !b && a[0];
    a1   = a + 16'd1;
    e.rd = !w; e.err = 1'b0; e.data = '0;
    if (exp_to) e.err = 1'b1;
`ifndef H80_BIU_UNALIGNED_EN
    else if (unal) e.err = 1'b1;
`endif
    else if (w) begin
      refm[a] = d[7:0];
      if (!b) refm[a1] = d[15:8];
    end else begin
      e.data = b ? {8'h00, refm[a]} : {refm[a1], refm[a]};
    end
    sbq.push_back(e);
    req = 1'b1; we = w; byte_en = b; addr_in = a; wdata = d;
    lat = 0; ce_lows = 0; ack_c = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      lat++;
      if (!ce_n) begin ce_lows++; seen_cmd = cmd; end
      if (ack) done = 1'b1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL ack_wait actual=no_ack expected=ack addr=%h", a);
    end
    ack_c = cyc;
    req = 1'b0;
  endtask

  initial begin
    int lat, cl, ac, ac1;
    logic [15:0] ra, rd;
    for (int i = 0; i < 65536; i++) refm[i] = 8'(i * 7 + 3);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ce_n", ce_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset during T2 of a read
    @(negedge clk);
    req = 1'b1; we = 1'b0; byte_en = 1'b0; addr_in = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    chk("midrd_t2_ce_n", ce_n, 0);
    reset_n = 1'b0;
    #1;
    chk("midrd_rst_ce_n", ce_n, 1);
    req = 1'b0;
    repeat (3) begin @(negedge clk); chk("midrd_no_ack", ack, 0); end
    reset_n = 1'b1;
    issue(0, 0, 16'h0010, 16'h0, 0, lat, cl, ac);
    chk("rd_after_rst_lat", lat, 3);

    // word write / readback
    @(negedge clk);
    issue(1, 0, 16'h0100, 16'h1234, 0, lat, cl, ac);
    chk("ww_lat", lat, 2);
    chk("ww_ce_cycles", cl, 1);
    chk("ww_cmd", seen_cmd, C_WRITE_W);
    chk("ww_data_released", data_ === 16'h1234, 0);
    @(negedge clk);
    issue(0, 0, 16'h0100, 16'h0, 0, lat, cl, ac);
    chk("wr_lat", lat, 3);
    chk("wr_ce_cycles", cl, 2);
    chk("wr_cmd", seen_cmd, C_READ_W);
    chk("wr_rdata", rdata, 16'h1234);

    // byte write, merged word read, byte read
    @(negedge clk);
    issue(1, 1, 16'h0101, 16'h00AB, 0, lat, cl, ac);
    chk("bw_cmd", seen_cmd, C_WRITE_B);
    @(negedge clk);
    issue(0, 0, 16'h0100, 16'h0, 0, lat, cl, ac);
    chk("merge_rdata", rdata, 16'hAB34);
    @(negedge clk);
    issue(0, 1, 16'h0101, 16'h0, 0, lat, cl, ac);
    chk("br_rdata", rdata, 16'h00AB);
    chk("br_cmd", seen_cmd, C_READ_B);

    // three wait states in T1
    wmode = 3; wlow_n = 3;
    @(negedge clk);
    issue(0, 0, 16'h0100, 16'h0, 0, lat, cl, ac);
    chk("wait3_lat", lat, 6);
    chk("wait3_rdata", rdata, 16'hAB34);

    // stuck wait_n -> timeout abort
    wmode = 2;
    @(negedge clk);
    issue(0, 0, 16'h0200, 16'h0, 1, lat, cl, ac);
    chk("to_rd_lat", lat, TO + 1);
    chk("to_rd_err", err, 1);
    @(negedge clk);
    issue(1, 0, 16'h0202, 16'hDEAD, 1, lat, cl, ac);
    chk("to_wr_mem_lo", smem[16'h0202], refm[16'h0202]);
    wmode = 0;

    // unaligned word write/read across the top of the address space
    @(negedge clk);
    issue(1, 0, 16'hFFFF, 16'hBEEF, 0, lat, cl, ac);
`ifdef H80_BIU_UNALIGNED_EN
    chk("unal_wr_lat", lat, 3);
    chk("unal_wr_ce_cycles", cl, 2);
    chk("unal_mem_ffff", smem[16'hFFFF], 8'hEF);
    chk("unal_mem_0000", smem[16'h0000], 8'hBE);
    @(negedge clk);
    issue(0, 0, 16'hFFFF, 16'h0, 0, lat, cl, ac);
    chk("unal_rd_lat", lat, 5);
    chk("unal_rd_rdata", rdata, 16'hBEEF);
`else
    chk("unal_rej_lat", lat, 1);
    chk("unal_rej_ce_cycles", cl, 0);
    chk("unal_rej_err", err, 1);
    chk("unal_rej_mem", smem[16'hFFFF], refm[16'hFFFF]);
`endif

    // back-to-back: second ce_n falls two cycles after first ack
    @(negedge clk);
    issue(1, 0, 16'h0300, 16'h5555, 0, lat, cl, ac1);
    issue(1, 1, 16'h0303, 16'h0077, 0, lat, cl, ac);
    chk("b2b_gap", last_fall - ac1, 2);

    // random traffic over a small window plus the wrap corner
    wmode = 1;
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 31));
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd, 0, lat, cl, ac);
    end
    for (int i = 0; i < 32; i += 2) issue(0, 0, 16'(i), 16'h0, 0, lat, cl, ac);
    wmode = 0;
    for (int i = 0; i < 32; i++) chk("mem_final", smem[i], refm[i]);
    chk("mem_final_fffe", smem[16'hFFFE], refm[16'hFFFE]);
    chk("mem_final_ffff", smem[16'hFFFF], refm[16'hFFFF]);
    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
